mem_port_arbiter: RTL and testbench

//  Shares the single 256-bit data-memory port between two cache refill/writeback masters
//  (port 0: dcache, port 1: icache). Each master uses the same enable/write/addr/data/ack

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 105 ++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester ports and the shared memory port of mem_port_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256
);
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic [DATA_W-1:0] p0_data_o;
    logic              p0_ack_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic [DATA_W-1:0] p1_data_o;
    logic              p1_ack_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic [DATA_W-1:0] mem_data_i;
    logic              mem_ack_i;

    logic              grant_o;
    logic              busy_o;

    modport master (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  mem_data_i, mem_ack_i,
        output p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output grant_o, busy_o
    );

    modport slave (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output mem_data_i, mem_ack_i,
        input  p0_data_o, p0_ack_o, p1_data_o, p1_ack_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  grant_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between dcache (port 0) and icache (port 1).
// One transaction in flight; memory-side signals are registered and held until mem_ack_i.
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int FIRST_PRI = 0
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_grant;
    logic              take;
    logic              winner;
    logic              done;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= S_IDLE;
        end else begin
            // NOTE: registers take <= so every flop samples pre-edge values, independent of block order.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: defaults first, so no path through the case leaves a signal unassigned (no latch).
        state_next = state;
        take       = 1'b0;
        winner     = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.p0_enable_i || bus.p1_enable_i) begin
                    take       = 1'b1;
                    state_next = S_BUSY;
                    // On a tie the port that did not own the last transaction wins.
                    if (bus.p0_enable_i && bus.p1_enable_i) winner = ~last_grant;
                    else                                    winner = bus.p1_enable_i;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack_i) begin
                    done       = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        sel_write = winner ? bus.p1_write_i : bus.p0_write_i;
        sel_addr  = winner ? bus.p1_addr_i  : bus.p0_addr_i;
        sel_data  = winner ? bus.p1_data_i  : bus.p0_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.mem_enable_o <= 1'b0;
            bus.mem_write_o  <= 1'b0;
            bus.mem_addr_o   <= '0;
            // NOTE: the wide line registers are reset too; they are outputs that must read zero in reset.
            bus.mem_data_o   <= '0;
            bus.p0_data_o    <= '0;
            bus.p1_data_o    <= '0;
            bus.p0_ack_o     <= 1'b0;
            bus.p1_ack_o     <= 1'b0;
            bus.grant_o      <= 1'b0;
            last_grant       <= 1'(FIRST_PRI == 0);
        end else begin
            bus.p0_ack_o <= done && !bus.grant_o;
            bus.p1_ack_o <= done &&  bus.grant_o;
            if (take) begin
                bus.mem_enable_o <= 1'b1;
                bus.mem_write_o  <= sel_write;
                bus.mem_addr_o   <= sel_addr;
                bus.mem_data_o   <= sel_data;
                bus.grant_o      <= winner;
            end
            if (done) begin
                bus.mem_enable_o <= 1'b0;
                bus.mem_write_o  <= 1'b0;
                last_grant       <= bus.grant_o;
                if (!bus.mem_write_o) begin
                    if (bus.grant_o) bus.p1_data_o <= bus.mem_data_i;
                    else             bus.p0_data_o <= bus.mem_data_i;
                end
            end
        end
    end

    assign bus.busy_o = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a table of arbitration vectors plus
// hand-written sequences for reset, held enables, spurious acks and back-to-back requests.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic clk = 1'b0;
    logic rst_i;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIRST_PRI(0)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    typedef struct {
        logic          req0;
        logic          req1;
        logic          wr0;
        logic          wr1;
        logic [AW-1:0] addr0;
        logic [AW-1:0] addr1;
        logic [DW-1:0] wd0;
        logic [DW-1:0] wd1;
        logic [DW-1:0] rd_a;
        logic [DW-1:0] rd_b;
        int            lat;
        logic          first;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] exp_d0 = '0;
    logic [DW-1:0] exp_d1 = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for the memory request, acks it after lat cycles, then steps into the idle cycle.
    task automatic serve(input int lat, input logic [DW-1:0] rdata, output int waited,
                         output logic g, output logic wr, output logic [AW-1:0] addr,
                         output logic [DW-1:0] wdata, output logic a0, output logic a1);
        logic stable;
        waited = 0;
        g = 1'b0; wr = 1'b0; addr = '0; wdata = '0; a0 = 1'b0; a1 = 1'b0;
        while (!bus.mem_enable_o && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.mem_enable_o) begin
            check("mem_enable timeout", 1'b0, 1'b1);
            return;
        end
        g     = bus.grant_o;
        wr    = bus.mem_write_o;
        addr  = bus.mem_addr_o;
        wdata = bus.mem_data_o;
        check("busy while request out", bus.busy_o, 1'b1);
        stable = 1'b1;
        repeat (lat) begin
            @(negedge clk);
            if (bus.mem_enable_o !== 1'b1 || bus.mem_addr_o !== addr || bus.mem_write_o !== wr ||
                bus.mem_data_o !== wdata || bus.grant_o !== g)
                stable = 1'b0;
        end
        check("mem outputs stable in busy", stable, 1'b1);
        bus.mem_data_i = rdata;
        bus.mem_ack_i  = 1'b1;
        @(negedge clk);
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        a0 = bus.p0_ack_o;
        a1 = bus.p1_ack_o;
        check("mem_enable cleared on ack", bus.mem_enable_o, 1'b0);
        check("mem_write cleared on ack", bus.mem_write_o, 1'b0);
        check("busy in resp", bus.busy_o, 1'b1);
        @(negedge clk);
        check("ack is one-cycle pulse", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        check("no request in resp", bus.mem_enable_o, 1'b0);
    endtask

    task automatic txn(input string tag, input logic exp_port, input logic wr, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int lat, input int exp_wait);
        int            waited;
        logic          g, w, a0, a1;
        logic [AW-1:0] ad;
        logic [DW-1:0] wdat;
        serve(lat, rd, waited, g, w, ad, wdat, a0, a1);
        check({tag, " grant"}, g, exp_port);
        check({tag, " mem_addr"}, ad, addr);
        check({tag, " mem_write"}, w, wr);
        check({tag, " mem_data"}, wdat, wd);
        check({tag, " p0_ack"}, a0, exp_port == 1'b0);
        check({tag, " p1_ack"}, a1, exp_port == 1'b1);
        if (exp_wait >= 0) check({tag, " rearb wait"}, waited, exp_wait);
        if (!wr) begin
            if (exp_port) exp_d1 = rd;
            else          exp_d0 = rd;
        end
        check({tag, " p0_data"}, bus.p0_data_o, exp_d0);
        check({tag, " p1_data"}, bus.p1_data_o, exp_d1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_enable"}, bus.mem_enable_o, 1'b0);
        check({tag, " mem_write"}, bus.mem_write_o, 1'b0);
        check({tag, " mem_addr"}, bus.mem_addr_o, '0);
        check({tag, " mem_data"}, bus.mem_data_o, '0);
        check({tag, " acks"}, {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        check({tag, " p0_data"}, bus.p0_data_o, '0);
        check({tag, " p1_data"}, bus.p1_data_o, '0);
        check({tag, " grant"}, bus.grant_o, 1'b0);
        check({tag, " busy"}, bus.busy_o, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h400,  32'h1000, {32{8'h11}}, {32{8'h22}},
                    {32{8'h3C}}, {32{8'hC3}}, 3, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h400,  32'h0,    '0, '0,
                    {32{8'hA5}}, '0, 10, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1400, 32'h1020, {32{8'h44}}, {32{8'h55}},
                    {32{8'h66}}, {32{8'h77}}, 2, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0,    32'h2000, '0, 256'h1234_5678,
                    {32{8'h88}}, '0, 1, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h800,  32'h20A0, {8{32'hDEADBEEF}}, {32{8'h99}},
                    {32{8'h5A}}, {32{8'hAA}}, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0C0,  32'h0,    256'h1, '0,
                    {32{8'hFF}}, '0, 0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h60,   32'h80,   '0, '0,
                    {32{8'h0F}}, {32{8'hF0}}, 1, 1'b1};

        rst_i = 1'b0;
        bus.p0_enable_i = 1'b0; bus.p0_write_i = 1'b0; bus.p0_addr_i = '0; bus.p0_data_i = '0;
        bus.p1_enable_i = 1'b0; bus.p1_write_i = 1'b0; bus.p1_addr_i = '0; bus.p1_data_i = '0;
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_i = 1'b1;
        @(negedge clk);
        check("idle after reset busy", bus.busy_o, 1'b0);

        for (int i = 0; i < NV; i++) begin
            v = vecs[i];
            @(negedge clk);
            bus.p0_enable_i = v.req0; bus.p0_write_i = v.wr0; bus.p0_addr_i = v.addr0; bus.p0_data_i = v.wd0;
            bus.p1_enable_i = v.req1; bus.p1_write_i = v.wr1; bus.p1_addr_i = v.addr1; bus.p1_data_i = v.wd1;
            txn($sformatf("v%0d.a", i), v.first, v.first ? v.wr1 : v.wr0, v.first ? v.addr1 : v.addr0,
                v.first ? v.wd1 : v.wd0, v.rd_a, v.lat, -1);
            if (v.first) bus.p1_enable_i = 1'b0;
            else         bus.p0_enable_i = 1'b0;
            if (v.req0 && v.req1) begin
                txn($sformatf("v%0d.b", i), ~v.first, v.first ? v.wr0 : v.wr1, v.first ? v.addr0 : v.addr1,
                    v.first ? v.wd0 : v.wd1, v.rd_b, v.lat, 1);
                bus.p0_enable_i = 1'b0;
                bus.p1_enable_i = 1'b0;
            end
            repeat (2) @(negedge clk);
        end

        // Writeback then refill with enable held while port 1 waits: p0 W, p1 R, p0 R.
        @(negedge clk);
        bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b1; bus.p0_addr_i = 32'h800; bus.p0_data_i = 256'h1;
        @(negedge clk);
        bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h3000; bus.p1_data_i = '0;
        txn("wb p0 write", 1'b0, 1'b1, 32'h800, 256'h1, {32{8'hEE}}, 4, 0);
        bus.p0_write_i = 1'b0; bus.p0_addr_i = 32'h400; bus.p0_data_i = '0;
        txn("wb p1 read", 1'b1, 1'b0, 32'h3000, '0, {32{8'h12}}, 2, 1);
        bus.p1_enable_i = 1'b0;
        txn("wb p0 refill", 1'b0, 1'b0, 32'h400, '0, {32{8'h34}}, 2, 1);
        bus.p0_enable_i = 1'b0;
        repeat (2) @(negedge clk);

        // Spurious memory ack while idle must not reach either requester.
        bus.mem_ack_i = 1'b1; bus.mem_data_i = {32{8'hBD}};
        @(negedge clk);
        bus.mem_ack_i = 1'b0; bus.mem_data_i = '0;
        check("spurious ack acks", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        check("spurious ack p0_data", bus.p0_data_o, exp_d0);
        check("spurious ack p1_data", bus.p1_data_o, exp_d1);
        @(negedge clk);
        check("spurious ack later acks", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        check("spurious ack busy", bus.busy_o, 1'b0);

        // Port 1 drops its request and scrambles its address mid-transaction.
        bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h4000; bus.p1_data_i = {32{8'h01}};
        @(negedge clk);
        @(negedge clk);
        bus.p1_enable_i = 1'b0; bus.p1_addr_i = 32'hFFFF_FFE0; bus.p1_write_i = 1'b1;
        txn("drop p1", 1'b1, 1'b0, 32'h4000, {32{8'h01}}, {32{8'h5C}}, 3, 0);
        repeat (2) @(negedge clk);

        // Back-to-back port 1 reads with enable held across the ack.
        bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h5000; bus.p1_data_i = '0;
        txn("b2b first", 1'b1, 1'b0, 32'h5000, '0, {32{8'hC1}}, 2, -1);
        bus.p1_addr_i = 32'h5020;
        txn("b2b second", 1'b1, 1'b0, 32'h5020, '0, {32{8'hC2}}, 3, 1);
        bus.p1_enable_i = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a transaction.
        bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b1; bus.p0_addr_i = 32'h6000; bus.p0_data_i = {32{8'h77}};
        repeat (3) @(negedge clk);
        check("pre-reset mem_enable", bus.mem_enable_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        exp_d0 = '0;
        exp_d1 = '0;
        check_all_zero("async reset");
        bus.p0_enable_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b1;
        bus.mem_ack_i = 1'b1;
        @(negedge clk);
        bus.mem_ack_i = 1'b0;
        check("post-reset stale ack", {bus.p0_ack_o, bus.p1_ack_o}, 2'b00);
        check("post-reset busy", bus.busy_o, 1'b0);

        // Tie right after reset goes to FIRST_PRI again.
        @(negedge clk);
        bus.p0_enable_i = 1'b1; bus.p0_write_i = 1'b0; bus.p0_addr_i = 32'h7000; bus.p0_data_i = '0;
        bus.p1_enable_i = 1'b1; bus.p1_write_i = 1'b0; bus.p1_addr_i = 32'h7020; bus.p1_data_i = '0;
        txn("post-reset tie a", 1'b0, 1'b0, 32'h7000, '0, {32{8'h3A}}, 1, -1);
        bus.p0_enable_i = 1'b0;
        txn("post-reset tie b", 1'b1, 1'b0, 32'h7020, '0, {32{8'hA3}}, 1, 1);
        bus.p1_enable_i = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
